// File: rtl/uart_alu_ctrl.sv
// Frame controller: receives operand A, operand B and opcode, then sends one ALU result byte over UART.
// Optional inter-byte timeout is built when UART_CTRL_TIMEOUT_EN is defined.
module uart_alu_ctrl #(
    parameter int unsigned NB_DATA        = 8,
    parameter int unsigned NB_OP          = 6,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_overrun,
    output logic               o_timeout
);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        SEND    = 3'd3,
        WAIT_TX = 3'd4
    } state_t;

    state_t state;
    logic   expired;

    if (TIMEOUT_CYCLES < 2 || NB_OP > NB_DATA) begin : g_param_check
        $error("uart_alu_ctrl: TIMEOUT_CYCLES must be >= 2 and NB_OP <= NB_DATA");
    end

`ifdef UART_CTRL_TIMEOUT_EN
    logic [31:0] cnt;

    // A byte in the expiry cycle takes priority over the timeout.
    assign expired = (state == WAIT_B || state == WAIT_OP) && !i_rx_done
                     && (cnt == TIMEOUT_CYCLES - 32'd1);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt       <= '0;
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= expired;
            if ((state == WAIT_B || state == WAIT_OP) && !i_rx_done && !expired)
                cnt <= cnt + 32'd1;
            else
                cnt <= '0;
        end
    end
`else
    assign expired   = 1'b0;
    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= WAIT_A;
            o_alu_a    <= '0;
            o_alu_b    <= '0;
            o_alu_op   <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_busy     <= 1'b0;
            o_overrun  <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            o_overrun  <= 1'b0;
            case (state)
                WAIT_A: begin
                    if (i_rx_done) begin
                        o_alu_a <= i_rx_data;
                        state   <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (i_rx_done) begin
                        o_alu_b <= i_rx_data;
                        state   <= WAIT_OP;
                    end else if (expired) begin
                        state <= WAIT_A;
                    end
                end
                WAIT_OP: begin
                    if (i_rx_done) begin
                        o_alu_op <= i_rx_data[NB_OP-1:0];
                        o_busy   <= 1'b1;
                        state    <= SEND;
                    end else if (expired) begin
                        state <= WAIT_A;
                    end
                end
                SEND: begin
                    o_tx_data  <= i_alu_result;
                    o_tx_start <= 1'b1;
                    o_overrun  <= i_rx_done;
                    state      <= WAIT_TX;
                end
                WAIT_TX: begin
                    // Bytes are dropped here even when tx_done arrives in the same cycle.
                    o_overrun <= i_rx_done;
                    if (i_tx_done) begin
                        o_busy <= 1'b0;
                        state  <= WAIT_A;
                    end
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= WAIT_A;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_alu_ctrl.md
# uart_alu_ctrl

Frame controller between the UART receiver, the ALU and the UART transmitter. It collects three received bytes in order: operand A, operand B, then opcode. It drives them to the combinational ALU, captures the result and launches one transmit of the result byte. After that it waits for the transmitter to finish before accepting the next frame.

## Interface

Parameters:
- `NB_DATA`, default 8: width of operands, result and UART byte.
- `NB_OP`, default 6: opcode width, taken from the low bits of the third byte.
- `TIMEOUT_CYCLES`, default 1000000: inter-byte timeout in clock cycles. Used only with `UART_CTRL_TIMEOUT_EN`; must be ≥2 and fit in 32 bits.

Ports:
- `i_clk`, in, 1: system clock; all state changes on the rising edge.
- `i_reset_n`, in, 1: asynchronous, active-low reset.
- `i_rx_data`, in, NB_DATA: received byte; valid while `i_rx_done` is high.
- `i_rx_done`, in, 1: single-cycle pulse, one byte received.
- `i_alu_result`, in, NB_DATA: combinational ALU output.
- `i_tx_done`, in, 1: single-cycle pulse, transmitter finished the stop bit.
- `o_alu_a`, out, NB_DATA: registered operand A.
- `o_alu_b`, out, NB_DATA: registered operand B.
- `o_alu_op`, out, NB_OP: registered opcode.
- `o_tx_data`, out, NB_DATA: registered byte to transmit.
- `o_tx_start`, out, 1: single-cycle transmit request.
- `o_busy`, out, 1: high in states SEND and WAIT_TX.
- `o_overrun`, out, 1: single-cycle pulse, a received byte was discarded.
- `o_timeout`, out, 1: single-cycle pulse, partial frame abandoned. Tied 0 without the macro.

## Operation

States: WAIT_A, WAIT_B, WAIT_OP, SEND, WAIT_TX. Reset state is WAIT_A.

- **WAIT_A**, on `i_rx_done`: `o_alu_a` <= `i_rx_data`; go to WAIT_B.
- **WAIT_B**, on `i_rx_done`: `o_alu_b` <= `i_rx_data`; go to WAIT_OP.
- **WAIT_OP**, on `i_rx_done`: `o_alu_op` <= `i_rx_data[NB_OP-1:0]`; go to SEND. The upper bits of the byte are ignored.
- **SEND**, unconditional for one cycle: `o_tx_data` <= `i_alu_result`; `o_tx_start` <= 1; go to WAIT_TX.
- **WAIT_TX**, on `i_tx_done`: go to WAIT_A.
- Any other encoding goes to WAIT_A.

Register behaviour:
- `o_alu_a`, `o_alu_b` and `o_alu_op` hold their value until overwritten; they are never cleared except by reset.
- `i_tx_done` outside WAIT_TX is ignored.

Discarded bytes:
- `i_rx_done` in SEND or WAIT_TX discards the byte and pulses `o_overrun` on the next cycle.
- This also applies when `i_rx_done` and `i_tx_done` are high in the same WAIT_TX cycle: the state still moves to WAIT_A and the byte is dropped.

Reset:
- Asserting `i_reset_n` low at any point, mid-frame included, immediately forces WAIT_A.
- All outputs and registers are cleared to 0.
- An in-flight transmit is not tracked after reset.

## Timing

- `o_alu_*` are valid 1 cycle after the corresponding `i_rx_done`.
- Third-byte `i_rx_done` in cycle N:
  - `o_alu_op` is valid and the state is SEND in N+1.
  - `o_tx_start` = 1 and `o_tx_data` is valid in N+2, with `o_busy` = 1 from N+1.
  - `o_tx_start` returns to 0 in N+3.
- `o_tx_data` holds until the next SEND. Only one `o_tx_start` pulse is issued per frame.
- `i_tx_done` in cycle M gives state WAIT_A and `o_busy` = 0 in M+1. A byte arriving at M+1 is accepted as A.
- All outputs are registered; none depends combinationally on inputs.

## Configuration

Macro: `UART_CTRL_TIMEOUT_EN`.

Defined:
- A 32-bit counter runs in WAIT_B and WAIT_OP and clears on every `i_rx_done` and in every other state.
- When the counter reaches `TIMEOUT_CYCLES-1` with no `i_rx_done` that cycle:
  - the state goes to WAIT_A and the counter clears;
  - `o_timeout` pulses in the next cycle;
  - operand registers keep their values.
- `i_rx_done` in the expiry cycle wins: the byte is accepted and there is no timeout.

Undefined:
- No counter is built; `o_timeout` is constant 0.
- A partial frame waits indefinitely.

## Test plan

- Reset, then bytes 0x05, 0x03, 0x20 (add), with the ALU model giving 0x08 → `o_alu_a` = 0x05, `o_alu_b` = 0x03, `o_alu_op` = 6'h20, one `o_tx_start` pulse 2 cycles after the third `i_rx_done`, `o_tx_data` = 0x08.
- Third byte 0xE2 → `o_alu_op` = 6'h22; upper bits dropped.
- Byte 0x11 during WAIT_TX → `o_overrun` pulse, `o_alu_a` unchanged. After `i_tx_done`, bytes 0x01, 0x02, 0x20 produce `o_tx_data` = 0x03.
- `i_reset_n` low after two bytes of a frame → all outputs 0, state WAIT_A. The next three bytes 0x0A, 0x0B, 0x20 form a full frame.
- With `UART_CTRL_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 100:
  - 1 byte, then silence → `o_timeout` pulse 100 cycles later, back to WAIT_A.
  - A byte arriving exactly in the expiry cycle → accepted, no `o_timeout`.
- `i_rx_done` and `i_tx_done` in the same WAIT_TX cycle → WAIT_A next cycle, `o_overrun` pulse, byte not latched.
